// File: rtl/odd_par_chk.sv
// odd_par_chk: serial odd-parity frame checker.
// Each frame is N data bits (LSB first) followed by one odd-parity bit. The
// data word is reassembled and presented with a parity-error flag through a
// one-entry valid/ready output buffer. The parity bit is the only bit that
// can stall, and only while the buffer is full and not draining.
// Optional feature: define ODD_PAR_CHK_ERR_CNT_EN to enable the saturating
// parity-error counter on err_cnt; otherwise err_cnt is tied to zero.
module odd_par_chk #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic [N-1:0] data_out,
  output logic         par_err,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   err_cnt
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           acc_q, acc_d;
  logic [N-1:0]   data_q, data_d;
  logic           perr_q, perr_d;
  logic           valid_q, valid_d;

  logic           bit_acc;
  logic           par_load;
  logic           frame_err;

  // Data bits always pass; the parity bit needs room in the output buffer.
  assign bit_ready = (state_q == ST_DATA) || !valid_q || out_ready;
  assign bit_acc   = bit_valid && bit_ready;
  // A parity bit loads the buffer unless clr aborts the frame in this cycle.
  assign par_load  = bit_acc && !clr && (state_q == ST_PAR);
  // Even total parity over data plus parity bit is an error.
  assign frame_err = ~(acc_q ^ bit_in);

  assign data_out  = data_q;
  assign par_err   = perr_q;
  assign out_valid = valid_q;

  // Next-state logic for the frame FSM, shift register and output buffer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q;

    if (clr) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      acc_d   = 1'b0;
      shift_d = '0;
    end else if (bit_acc) begin
      unique case (state_q)
        ST_DATA: begin
          shift_d[cnt_q] = bit_in;
          acc_d          = acc_q ^ bit_in;
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PAR: begin
          data_d  = shift_q;
          perr_d  = frame_err;
          acc_d   = 1'b0;
          state_d = ST_DATA;
        end
        default: state_d = ST_DATA;
      endcase
    end

    // Reload wins over drain so back-to-back frames keep out_valid high.
    if (par_load) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
    end
  end

`ifdef ODD_PAR_CHK_ERR_CNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  // Count frames loaded with a parity error, saturating at 255.
  always_comb begin
    ecnt_d = ecnt_q;
    if (par_load && frame_err && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  // Error counter register; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= 8'd0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_cnt = ecnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_odd_par_chk.sv
// tb_odd_par_chk: self-checking bench for odd_par_chk (N = 8).
// Expected values come from a frame-level model: the word sent, the parity
// rule on the count of ones, and a running total of loaded error frames.
module tb_odd_par_chk;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic [N-1:0] data_out;
  logic         par_err;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   err_cnt;

  int checks;
  int errors;
  int err_total;

  odd_par_chk #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .data_out  (data_out),
    .par_err   (par_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is bad when data ones plus parity bit is even.
  function automatic logic model_err(input logic [N-1:0] d, input logic p);
    return (($countones(d) + int'(p)) % 2) == 0;
  endfunction

  function automatic logic [7:0] model_cnt();
`ifdef ODD_PAR_CHK_ERR_CNT_EN
    return (err_total > 255) ? 8'd255 : 8'(err_total);
`else
    return 8'd0;
`endif
  endfunction

  // Offer one bit and wait (bounded) until it is accepted.
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (bit_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_bit_timeout: bit_ready=%0b required=1", bit_ready);
  endtask

  task automatic send_data(input logic [N-1:0] d);
    for (int i = 0; i < N; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic p);
    send_data(d);
    send_bit(p);
    if (model_err(d, p)) err_total++;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    err_total = 0;
    #3;
    checks++;
    if ({data_out, par_err, out_valid, err_cnt, bit_ready} !== {{N{1'b0}}, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: data=%h perr=%b valid=%b cnt=%0d rdy=%b required 00/0/0/0/1",
               data_out, par_err, out_valid, err_cnt, bit_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0] d_tab [3];
    logic         p_tab [3];
    d_tab[0] = 8'h00; p_tab[0] = 1'b1;
    d_tab[1] = 8'hA5; p_tab[1] = 1'b1;
    d_tab[2] = 8'hA5; p_tab[2] = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_frame(d_tab[k], p_tab[k]);
      checks++;
      if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, d_tab[k], model_err(d_tab[k], p_tab[k]), model_cnt()}) begin
        errors++;
        $display("FAIL basic_%0d: valid=%b data=%h perr=%b cnt=%0d required 1/%h/%b/%0d",
                 k, out_valid, data_out, par_err, err_cnt, d_tab[k], model_err(d_tab[k], p_tab[k]), model_cnt());
      end
    end
    idle();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid=%b required=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] d1;
    d1 = 8'h11;
    out_ready = 1'b0;
    send_frame(d1, 1'b1);
    for (int i = 0; i < N; i++) begin
      bit_valid = 1'b1;
      bit_in    = d1[0] ^ 1'b0;
      bit_in    = (8'h3C >> i) & 1;
      #1;
      checks++;
      if (bit_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_data_ready_%0d: bit_ready=%b required=1", i, bit_ready);
      end
      @(posedge clk); #1;
    end
    bit_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++;
      if ({bit_ready, out_valid, data_out, par_err} !== {1'b0, 1'b1, d1, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall_%0d: rdy=%b valid=%b data=%h perr=%b required 0/1/%h/0",
                 t, bit_ready, out_valid, data_out, par_err, d1);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: bit_ready=%b required=1", bit_ready);
    end
    @(posedge clk); #1;
    idle();
    checks++;
    if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, 8'h3C, 1'b0, model_cnt()}) begin
      errors++;
      $display("FAIL bp_reload: valid=%b data=%h perr=%b cnt=%0d required 1/3c/0/%0d",
               out_valid, data_out, par_err, err_cnt, model_cnt());
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b required=0", out_valid);
    end
  endtask

  task automatic test_clr();
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    clr       = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    idle();
    checks++;
    if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, 8'h5A, 1'b1, model_cnt()}) begin
      errors++;
      $display("FAIL clr_buffer_kept: valid=%b data=%h perr=%b cnt=%0d required 1/5a/1/%0d",
               out_valid, data_out, par_err, err_cnt, model_cnt());
    end
    send_data(8'h81);
    out_ready = 1'b1;
    send_bit(1'b1);
    idle();
    checks++;
    if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, 8'h81, 1'b0, model_cnt()}) begin
      errors++;
      $display("FAIL clr_next_frame: valid=%b data=%h perr=%b cnt=%0d required 1/81/0/%0d",
               out_valid, data_out, par_err, err_cnt, model_cnt());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    send_frame(8'h3E, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #1;
    rst_n = 1'b0;
    err_total = 0;
    #1;
    checks++;
    if ({data_out, par_err, out_valid, err_cnt} !== {{N{1'b0}}, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset: data=%h perr=%b valid=%b cnt=%0d required 00/0/0/0",
               data_out, par_err, out_valid, err_cnt);
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'hFF, 1'b1);
    idle();
    checks++;
    if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, 8'hFF, 1'b0, model_cnt()}) begin
      errors++;
      $display("FAIL post_reset_frame: valid=%b data=%h perr=%b cnt=%0d required 1/ff/0/%0d",
               out_valid, data_out, par_err, err_cnt, model_cnt());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic         p;
    for (int k = 0; k < 24; k++) begin
      d = N'($urandom);
      p = 1'($urandom);
      out_ready = 1'($urandom);
      send_data(d);
      out_ready = 1'b1;
      send_bit(p);
      if (model_err(d, p)) err_total++;
      checks++;
      if ({out_valid, data_out, par_err, err_cnt} !== {1'b1, d, model_err(d, p), model_cnt()}) begin
        errors++;
        $display("FAIL random_%0d: valid=%b data=%h perr=%b cnt=%0d required 1/%h/%b/%0d",
                 k, out_valid, data_out, par_err, err_cnt, d, model_err(d, p), model_cnt());
      end
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_err_cnt();
    logic [N-1:0] d;
    out_ready = 1'b1;
    for (int k = 0; k < 260; k++) begin
      d = N'($urandom);
      send_frame(d, ^d);
      checks++;
      if ({par_err, err_cnt} !== {1'b1, model_cnt()}) begin
        errors++;
        $display("FAIL err_cnt_%0d: perr=%b cnt=%0d required 1/%0d", k, par_err, err_cnt, model_cnt());
      end
    end
    idle();
    @(posedge clk); #1;
    checks++;
`ifdef ODD_PAR_CHK_ERR_CNT_EN
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt_saturate: cnt=%0d required=255", err_cnt);
    end
`else
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_cnt_tied: cnt=%0d required=0", err_cnt);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_clr();
    test_mid_reset();
    test_random();
    test_err_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
